// File: rtl/load_store_unit.sv
// Load/store stage: turns ALU effective address + rs2 into data-memory requests and
// formats load data. Optional MISALIGN_TRAP_EN makes misaligned H/W accesses trap.
module load_store_unit #(
  parameter int DMEM_AW      = 14,
  parameter int READ_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               is_load,
  input  logic               is_store,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr,
  input  logic [31:0]        store_data,
  output logic               resp_valid,
  output logic [31:0]        load_data,
  output logic               misaligned,
  output logic               dmem_en,
  output logic [3:0]         dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_din,
  input  logic [31:0]        dmem_dout
);

  localparam int CW = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, LWAIT, RESP} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt;
  logic [2:0]     f3_q;
  logic [1:0]     off_q;
  logic [31:0]    data_q;
  logic           mis_q;

  logic [1:0]     off, eff_off;
  logic           sz_half, sz_word, ld_ok, st_ok, legal, mis;
  logic           accept, access, ld_access;
  logic           addr_unused;

  // Address bits above the memory are deliberately dropped (accesses wrap).
  assign addr_unused = &{1'b0, addr[31:DMEM_AW+2]};

  assign off     = addr[1:0];
  assign sz_half = (funct3[1:0] == 2'b01);
  assign sz_word = (funct3[1:0] == 2'b10);
  assign ld_ok   = !(funct3 == 3'b011 || funct3[2:1] == 2'b11);
  assign st_ok   = !funct3[2] && (funct3[1:0] != 2'b11);
  assign legal   = is_load ? ld_ok : st_ok;

`ifdef MISALIGN_TRAP_EN
  assign mis = legal && ((sz_half && off[0]) || (sz_word && off != 2'b00));
`else
  assign mis = 1'b0;
`endif

  // Without trapping, halves ignore addr[0] and words ignore addr[1:0].
  assign eff_off = sz_half ? {off[1], 1'b0} : (sz_word ? 2'b00 : off);

  assign req_ready = (state == IDLE);
  assign accept    = req_ready && req_valid && (is_load || is_store);
  assign access    = accept && legal && !mis;
  assign ld_access = access && is_load;

  always_comb begin
    dmem_en   = 1'b0;
    dmem_we   = 4'b0000;
    dmem_addr = '0;
    dmem_din  = 32'h0;
    if (access) begin
      dmem_en   = 1'b1;
      dmem_addr = addr[DMEM_AW+1:2];
      if (!is_load) begin
        if (sz_word) begin
          dmem_we  = 4'b1111;
          dmem_din = store_data;
        end else if (sz_half) begin
          dmem_we  = eff_off[1] ? 4'b1100 : 4'b0011;
          dmem_din = {2{store_data[15:0]}};
        end else begin
          dmem_we  = 4'b0001 << eff_off;
          dmem_din = {4{store_data[7:0]}};
        end
      end
    end
  end

  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] o,
                                      input logic [31:0] d);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = d >> {o, 3'b000};
    b  = sh[7:0];
    h  = o[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  fmt = {{24{b[7]}}, b};
      3'b100:  fmt = {24'h0, b};
      3'b001:  fmt = {{16{h[15]}}, h};
      3'b101:  fmt = {16'h0, h};
      3'b010:  fmt = d;
      default: fmt = 32'h0;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = ld_access ? LWAIT : RESP;
      LWAIT:   if (cnt == CW'(READ_LATENCY)) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      f3_q   <= 3'b000;
      off_q  <= 2'b00;
      data_q <= 32'h0;
      mis_q  <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (accept) begin
          cnt    <= CW'(1);
          f3_q   <= funct3;
          off_q  <= eff_off;
          data_q <= 32'h0;
          mis_q  <= mis;
        end
        LWAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(READ_LATENCY)) data_q <= fmt(f3_q, off_q, dmem_dout);
        end
        default: ;
      endcase
    end
  end

  assign resp_valid = (state == RESP);
  assign load_data  = resp_valid ? data_q : 32'h0;
  assign misaligned = resp_valid && mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench: two DUT copies (READ_LATENCY 1 and 3) share stimulus; each has its own
// memory model and response scoreboard. Vector table + hand-written corner sequences.
module tb_load_store_unit;
  localparam int N = 2;
  localparam int LAT [N] = '{1, 3};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        req_ready [N];
  logic        resp_valid [N];
  logic        misaligned [N];
  logic        dmem_en [N];
  logic [31:0] load_data [N];
  logic [31:0] dmem_din [N];
  logic [31:0] dmem_dout [N];
  logic [3:0]  dmem_we [N];
  logic [13:0] dmem_addr [N];

  typedef struct {
    logic ld, st; logic [2:0] f3; logic [31:0] a, sd;
    logic en; logic [3:0] we; logic [31:0] din; logic [13:0] da;
    logic [31:0] ldd; logic mis;
  } vec_t;
  typedef struct { logic [31:0] data; logic mis; int due; } rsp_t;

  rsp_t sb [N][$];
  vec_t vt [$];
  vec_t cur;
  int   checks = 0, errors = 0, cyc = 0;
  int   acc_cnt [N];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : inst
    localparam int L = LAT[g];
    logic [31:0] mem [64];
    logic [31:0] rp [L];

    load_store_unit #(.DMEM_AW(14), .READ_LATENCY(L)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready[g]),
      .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
      .store_data(store_data), .resp_valid(resp_valid[g]), .load_data(load_data[g]),
      .misaligned(misaligned[g]), .dmem_en(dmem_en[g]), .dmem_we(dmem_we[g]),
      .dmem_addr(dmem_addr[g]), .dmem_din(dmem_din[g]), .dmem_dout(dmem_dout[g]));

    // Read data is only meaningful exactly L cycles after a read; junk otherwise.
    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        mem[0] <= 32'h8001_1234;
        mem[1] <= 32'h7654_3210;
      end else if (dmem_en[g]) begin
        for (int b = 0; b < 4; b++)
          if (dmem_we[g][b]) mem[dmem_addr[g][5:0]][8*b +: 8] <= dmem_din[g][8*b +: 8];
      end
      rp[0] <= (dmem_en[g] && dmem_we[g] == 4'b0000) ? mem[dmem_addr[g][5:0]] : 32'hBAD0_BAD0;
      for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
    end
    assign dmem_dout[g] = rp[L-1];
  end

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s: got %h, want %h (cycle %0d)", k, nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        if (req_valid && req_ready[k] && (is_load || is_store)) begin
          acc_cnt[k]++;
          chk(k, "dmem_en", 32'(dmem_en[k]), 32'(cur.en));
          chk(k, "dmem_we", 32'(dmem_we[k]), 32'(cur.we));
          chk(k, "dmem_din", dmem_din[k], cur.din);
          if (cur.en) chk(k, "dmem_addr", 32'(dmem_addr[k]), 32'(cur.da));
          sb[k].push_back('{cur.ldd, cur.mis, cyc + ((cur.en && cur.ld) ? LAT[k] + 1 : 1)});
        end else begin
          chk(k, "dmem_idle", {dmem_en[k], dmem_we[k], 27'h0}, 32'h0);
          chk(k, "dmem_din_idle", dmem_din[k], 32'h0);
        end
        if (resp_valid[k]) begin
          if (sb[k].size() == 0) begin
            checks++; errors++;
            $display("FAIL inst%0d unexpected_resp: got resp_valid=1, want 0 (cycle %0d)", k, cyc);
          end else begin
            rsp_t r;
            r = sb[k].pop_front();
            chk(k, "resp_cycle", 32'(cyc), 32'(r.due));
            chk(k, "load_data", load_data[k], r.data);
            chk(k, "misaligned", 32'(misaligned[k]), 32'(r.mis));
          end
        end else begin
          chk(k, "load_data_idle", load_data[k], 32'h0);
        end
      end
    end
  end

  function automatic vec_t mk(input logic ld, st, input logic [2:0] f3, input logic [31:0] a, sd,
                              input logic en, input logic [3:0] we, input logic [31:0] din,
                              input logic [13:0] da, input logic [31:0] ldd, input logic mis);
    vec_t v;
    v = '{ld, st, f3, a, sd, en, we, din, da, ldd, mis};
    return v;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (req_ready[0] && req_ready[1] && sb[0].size() == 0 && sb[1].size() == 0) return;
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL wait_idle: got busy after 60 cycles, want idle");
  endtask

  task automatic drive(input vec_t v);
    cur = v;
    is_load = v.ld; is_store = v.st; funct3 = v.f3; addr = v.a; store_data = v.sd;
    req_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    req_valid = 0; is_load = 0; is_store = 0; funct3 = 0; addr = 0; store_data = 0;
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    acc_cnt = '{0, 0};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk(k, "rst_ready", 32'(req_ready[k]), 32'h1);
      chk(k, "rst_resp_valid", 32'(resp_valid[k]), 32'h0);
      chk(k, "rst_load_data", load_data[k], 32'h0);
      chk(k, "rst_misaligned", 32'(misaligned[k]), 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    vt.push_back(mk(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 4'hF, 32'hDEADBEEF, 4, 0, 0));
    vt.push_back(mk(0, 1, 3'b000, 32'h13, 32'h000000A5, 1, 4'h8, 32'hA5A5A5A5, 4, 0, 0));
    vt.push_back(mk(1, 0, 3'b000, 32'h13, 0, 1, 0, 0, 4, 32'hFFFFFFA5, 0));
    vt.push_back(mk(1, 0, 3'b100, 32'h13, 0, 1, 0, 0, 4, 32'h000000A5, 0));
    vt.push_back(mk(1, 0, 3'b001, 32'h2, 0, 1, 0, 0, 0, 32'hFFFF8001, 0));
    vt.push_back(mk(1, 0, 3'b101, 32'h2, 0, 1, 0, 0, 0, 32'h00008001, 0));
    vt.push_back(mk(1, 0, 3'b001, 32'h0, 0, 1, 0, 0, 0, 32'h00001234, 0));
    vt.push_back(mk(0, 1, 3'b001, 32'h22, 32'h1234BEEF, 1, 4'hC, 32'hBEEFBEEF, 8, 0, 0));
    vt.push_back(mk(1, 0, 3'b010, 32'h20, 0, 1, 0, 0, 8, 32'hBEEF0000, 0));
    vt.push_back(mk(1, 0, 3'b000, 32'h22, 0, 1, 0, 0, 8, 32'hFFFFFFEF, 0));
    vt.push_back(mk(1, 0, 3'b100, 32'h21, 0, 1, 0, 0, 8, 32'h00000000, 0));
    vt.push_back(mk(1, 0, 3'b011, 32'h10, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 3'b011, 32'h10, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 3'b100, 32'h10, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 1, 3'b010, 32'h10, 32'h12345678, 1, 0, 0, 4, 32'hA5ADBEEF, 0));
    vt.push_back(mk(1, 0, 3'b010, 32'h80010004, 0, 1, 0, 0, 1, 32'h76543210, 0));
`ifdef MISALIGN_TRAP_EN
    vt.push_back(mk(1, 0, 3'b010, 32'h6, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(1, 0, 3'b001, 32'h3, 0, 0, 0, 0, 0, 0, 1));
    vt.push_back(mk(0, 1, 3'b001, 32'h21, 32'h5555, 0, 0, 0, 0, 0, 1));
`else
    vt.push_back(mk(1, 0, 3'b010, 32'h6, 0, 1, 0, 0, 1, 32'h76543210, 0));
    vt.push_back(mk(1, 0, 3'b001, 32'h3, 0, 1, 0, 0, 0, 32'hFFFF8001, 0));
    vt.push_back(mk(0, 1, 3'b001, 32'h21, 32'h5555, 1, 4'h3, 32'h55555555, 8, 0, 0));
`endif

    foreach (vt[i]) begin
      wait_idle();
      drive(vt[i]);
      @(negedge clk);
      req_valid = 1'b0;
    end

    // Request with neither flag set must be ignored.
    wait_idle();
    drive(mk(0, 0, 3'b010, 32'h10, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) chk(k, "noop_ready", 32'(req_ready[k]), 32'h1);
    req_valid = 1'b0;

    // Back-to-back: request held for 10 cycles; one accept per IDLE visit.
    wait_idle();
    acc_cnt = '{0, 0};
    drive(mk(1, 0, 3'b010, 32'h10, 0, 1, 0, 0, 4, 32'hA5ADBEEF, 0));
    repeat (10) @(negedge clk);
    req_valid = 1'b0;
    wait_idle();
    for (int k = 0; k < N; k++)
      chk(k, "b2b_accepts", 32'(acc_cnt[k]), 32'((10 + LAT[k] + 1) / (LAT[k] + 2)));

    // Reset while waiting on a load: response is dropped.
    wait_idle();
    drive(mk(1, 0, 3'b010, 32'h10, 0, 1, 0, 0, 4, 32'hA5ADBEEF, 0));
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < N; k++) sb[k].delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk(k, "post_rst_ready", 32'(req_ready[k]), 32'h1);
      chk(k, "post_rst_resp", 32'(resp_valid[k]), 32'h0);
    end
    repeat (6) @(negedge clk);
    for (int k = 0; k < N; k++) chk(k, "sb_empty", 32'(sb[k].size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
